// File: rtl/operand2_pkg.sv
// Shared codes for the operand-2 sequencer: shift/extend type codes,
// instruction class codes, operand forms, FSM states and the Rs shift-amount rule.
package operand2_pkg;

  localparam logic [2:0] SH_LSL  = 3'd0;
  localparam logic [2:0] SH_LSR  = 3'd1;
  localparam logic [2:0] SH_ASR  = 3'd2;
  localparam logic [2:0] SH_ROR  = 3'd3;
  localparam logic [2:0] SH_ROR2 = 3'd4;
  localparam logic [2:0] SH_LSL2 = 3'd5;

  localparam logic [2:0] EX_SB  = 3'd0;
  localparam logic [2:0] EX_UB  = 3'd1;
  localparam logic [2:0] EX_SH  = 3'd2;
  localparam logic [2:0] EX_UH  = 3'd3;
  localparam logic [2:0] EX_S24 = 3'd4;
  localparam logic [2:0] EX_U12 = 3'd5;

  // Values of instr[27:25]
  localparam logic [2:0] CL_DP_REG = 3'b000;
  localparam logic [2:0] CL_DP_IMM = 3'b001;
  localparam logic [2:0] CL_LS_IMM = 3'b010;
  localparam logic [2:0] CL_LS_REG = 3'b011;
  localparam logic [2:0] CL_BRANCH = 3'b101;

  typedef enum logic [2:0] {
    F_ILLEGAL,
    F_DP_IMM,
    F_IMM_SH,
    F_REG_SH,
    F_LS_IMM,
    F_BRANCH
  } form_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_RM,
    ST_RD_RS,
    ST_EMIT,
    ST_EMIT2
  } state_t;

  // Register-specified amount: linear shifts saturate at 32, ROR only uses Rs[4:0].
  function automatic logic [5:0] reg_shift_amount(input logic [1:0] ty, input logic [7:0] rs);
    if (ty == 2'b11)
      return {1'b0, rs[4:0]};
    else if (rs >= 8'd32)
      return 6'd32;
    else
      return rs[5:0];
  endfunction

endpackage

// File: rtl/operand2_classify.sv
// Combinational decode of the operand-2 form from instr[27:25] and instr[11:4];
// zero latency, no flow control.
module operand2_classify
  import operand2_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [11:4] fld,
  output form_t       form,
  output logic        needs_rm,
  output logic        needs_rs,
  output logic        e,
  output logic        last,
  output logic        illegal,
  output logic [2:0]  t,
  output logic [5:0]  shift_value
);

  always_comb begin
    form        = F_ILLEGAL;
    needs_rm    = 1'b0;
    needs_rs    = 1'b0;
    e           = 1'b0;
    last        = 1'b1;
    illegal     = 1'b1;
    t           = SH_LSL;
    shift_value = 6'd0;
    case (op)
      CL_DP_IMM: begin
        form        = F_DP_IMM;
        illegal     = 1'b0;
        t           = SH_ROR2;
        shift_value = {2'b00, fld[11:8]};
      end
      CL_DP_REG, CL_LS_REG: begin
        if (!fld[4]) begin
          form        = F_IMM_SH;
          needs_rm    = 1'b1;
          illegal     = 1'b0;
          t           = {1'b0, fld[6:5]};
          shift_value = {1'b0, fld[11:7]};
          // LSR/ASR #0 encode a 32-bit shift; ROR #0 stays a plain rotate by 0
          if ((fld[6:5] == 2'b01 || fld[6:5] == 2'b10) && fld[11:7] == 5'd0)
            shift_value = 6'd32;
        end else if (op == CL_DP_REG && !fld[7]) begin
          form     = F_REG_SH;
          needs_rm = 1'b1;
          needs_rs = 1'b1;
          illegal  = 1'b0;
          t        = {1'b0, fld[6:5]};
        end
      end
      CL_LS_IMM: begin
        form    = F_LS_IMM;
        illegal = 1'b0;
        e       = 1'b1;
        t       = EX_U12;
      end
      CL_BRANCH: begin
        form    = F_BRANCH;
        illegal = 1'b0;
        e       = 1'b1;
        t       = EX_S24;
        last    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/operand2_sequencer.sv
// Accepts one instruction, reads Rm/Rs, issues 1-2 registered shifter micro-ops.
// Latency 1/2/3 cycles by form; outputs hold while out_valid && !out_ready.
module operand2_sequencer
  import operand2_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0]     rf_rd_data,
  input  logic [DATA_W-1:0]     sx_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     shifter_in,
  output logic [5:0]            shift_value,
  output logic [2:0]            t,
  output logic                  E,
  output logic                  last,
  output logic                  illegal
);

  state_t state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] rm_q, rm_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] si_q, si_d;
  logic [5:0]        sv_q, sv_d;
  logic [2:0]        t_q, t_d;
  logic              e_q, e_d;
  logic              last_q, last_d;
  logic              ill_q, ill_d;

  logic [31:0] cls_word;
  form_t       c_form;
  logic        c_needs_rm, c_needs_rs, c_e, c_last, c_ill;
  logic [2:0]  c_t;
  logic [5:0]  c_sv;

  // In IDLE decode the offered word so immediate forms can load outputs on the accept edge
  assign cls_word = (state_q == ST_IDLE) ? instr : instr_q;

  operand2_classify u_classify (
    .op          (cls_word[27:25]),
    .fld         (cls_word[11:4]),
    .form        (c_form),
    .needs_rm    (c_needs_rm),
    .needs_rs    (c_needs_rs),
    .e           (c_e),
    .last        (c_last),
    .illegal     (c_ill),
    .t           (c_t),
    .shift_value (c_sv)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      rm_q    <= '0;
      vld_q   <= 1'b0;
      si_q    <= '0;
      sv_q    <= '0;
      t_q     <= '0;
      e_q     <= 1'b0;
      last_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rm_q    <= rm_d;
      vld_q   <= vld_d;
      si_q    <= si_d;
      sv_q    <= sv_d;
      t_q     <= t_d;
      e_q     <= e_d;
      last_q  <= last_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rm_d    = rm_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          instr_d = instr;
          state_d = c_needs_rm ? ST_RD_RM : ST_EMIT;
        end
      end
      ST_RD_RM: begin
        rm_d    = rf_rd_data;
        state_d = c_needs_rs ? ST_RD_RS : ST_EMIT;
      end
      ST_RD_RS: state_d = ST_EMIT;
      ST_EMIT: begin
        if (out_ready)
          state_d = last_q ? ST_IDLE : ST_EMIT2;
      end
      ST_EMIT2: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d  = vld_q;
    si_d   = si_q;
    sv_d   = sv_q;
    t_d    = t_q;
    e_d    = e_q;
    last_d = last_q;
    ill_d  = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !c_needs_rm) begin
          vld_d  = 1'b1;
          sv_d   = c_sv;
          t_d    = c_t;
          e_d    = c_e;
          last_d = c_last;
          ill_d  = c_ill;
          case (c_form)
            F_DP_IMM:           si_d = {{(DATA_W-8){1'b0}}, cls_word[7:0]};
            F_LS_IMM, F_BRANCH: si_d = DATA_W'(cls_word);
            default:            si_d = '0;
          endcase
        end
      end
      ST_RD_RM: begin
        if (!c_needs_rs) begin
          vld_d  = 1'b1;
          si_d   = rf_rd_data;
          sv_d   = c_sv;
          t_d    = c_t;
          e_d    = 1'b0;
          last_d = 1'b1;
          ill_d  = 1'b0;
        end
      end
      ST_RD_RS: begin
        vld_d  = 1'b1;
        si_d   = rm_q;
        sv_d   = reg_shift_amount(c_t[1:0], rf_rd_data[7:0]);
        t_d    = c_t;
        e_d    = 1'b0;
        last_d = 1'b1;
        ill_d  = 1'b0;
      end
      ST_EMIT, ST_EMIT2: begin
        if (out_ready) begin
          if (state_q == ST_EMIT && !last_q) begin
            // Second branch op: scale the sign-extended offset fed back from the shifter
            vld_d  = 1'b1;
            si_d   = sx_result;
            sv_d   = 6'd0;
            t_d    = SH_LSL2;
            e_d    = 1'b0;
            last_d = 1'b1;
            ill_d  = 1'b0;
          end else begin
            vld_d  = 1'b0;
            si_d   = '0;
            sv_d   = '0;
            t_d    = '0;
            e_d    = 1'b0;
            last_d = 1'b0;
            ill_d  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_RD_RM: rf_rd_addr = REG_ADDR_W'(instr_q[3:0]);
      ST_RD_RS: rf_rd_addr = REG_ADDR_W'(instr_q[11:8]);
      default:  rf_rd_addr = '0;
    endcase
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = vld_q;
  assign shifter_in  = si_q;
  assign shift_value = sv_q;
  assign t           = t_q;
  assign E           = e_q;
  assign last        = last_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_operand2_sequencer.sv
// Directed bench for operand2_sequencer with a small register-file model.
module tb_operand2_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [31:0] sx_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] shifter_in;
  logic [5:0]  shift_value;
  logic [2:0]  t;
  logic        E;
  logic        last;
  logic        illegal;

  logic [31:0] regs [16];
  logic [44:0] obs;
  logic [44:0] exp_v;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rf_rd_data = regs[rf_rd_addr];
  // {out_valid, illegal, last, E, t, shift_value, shifter_in}
  assign obs = {out_valid, illegal, last, E, t, shift_value, shifter_in};

  operand2_sequencer #(.REG_ADDR_W(4), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_data  (rf_rd_data),
    .sx_result   (sx_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .shifter_in  (shifter_in),
    .shift_value (shift_value),
    .t           (t),
    .E           (E),
    .last        (last),
    .illegal     (illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1; sx_result = '0;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (obs !== 45'd0) begin
      errors++; $display("FAIL reset_outputs got %h want %h", obs, 45'd0);
    end
    checks++;
    if ({in_ready, rf_rd_addr} !== 5'b1_0000) begin
      errors++; $display("FAIL reset_ready_addr got %b want %b", {in_ready, rf_rd_addr}, 5'b1_0000);
    end
  endtask

  task automatic test_dp_imm();
    instr = 32'h02A1_1A3F; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 6'd10, 32'h0000_003F};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL dp_imm_op got %h want %h", obs, exp_v);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL dp_imm_busy got %b want 0", in_ready);
    end
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL dp_imm_done got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_imm_shift(input logic [31:0] iw, input logic [31:0] rv,
                                input logic [2:0] et, input logic [5:0] esv);
    regs[iw[3:0]] = rv;
    instr = iw; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, rf_rd_addr} !== {1'b0, iw[3:0]}) begin
      errors++; $display("FAIL imm_sh_rd_rm %h got %h want %h", iw, {out_valid, rf_rd_addr}, {1'b0, iw[3:0]});
    end
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, et, esv, rv};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL imm_sh_op %h got %h want %h", iw, obs, exp_v);
    end
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL imm_sh_done %h got %b want 01", iw, {out_valid, in_ready});
    end
  endtask

  task automatic test_reg_shift(input logic [31:0] iw, input logic [31:0] rmv,
                                input logic [31:0] rsv, input logic [2:0] et, input logic [5:0] esv);
    regs[iw[3:0]] = rmv;
    regs[iw[11:8]] = rsv;
    instr = iw; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (rf_rd_addr !== iw[3:0]) begin
      errors++; $display("FAIL reg_sh_addr_rm %h got %0d want %0d", iw, rf_rd_addr, iw[3:0]);
    end
    step();
    checks++;
    if ({out_valid, rf_rd_addr} !== {1'b0, iw[11:8]}) begin
      errors++; $display("FAIL reg_sh_addr_rs %h got %h want %h", iw, {out_valid, rf_rd_addr}, {1'b0, iw[11:8]});
    end
    step();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, et, esv, rmv};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL reg_sh_op %h got %h want %h", iw, obs, exp_v);
    end
    step();
  endtask

  task automatic test_ls_imm();
    instr = 32'hE591_2004; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 6'd0, 32'hE591_2004};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL ls_imm_op got %h want %h", obs, exp_v);
    end
    step();
  endtask

  task automatic test_branch();
    instr = 32'hEAFF_FFFE; in_valid = 1'b1; out_ready = 1'b1; sx_result = 32'hFFFF_FFFE;
    step();
    in_valid = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 6'd0, 32'hEAFF_FFFE};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL branch_op1 got %h want %h", obs, exp_v);
    end
    step();
    sx_result = 32'h1234_5678;
    #1;
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 6'd0, 32'hFFFF_FFFE};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL branch_op2 got %h want %h", obs, exp_v);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL branch_busy got %b want 0", in_ready);
    end
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL branch_done got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_stall();
    instr = 32'h02A1_1A3F; in_valid = 1'b1; out_ready = 1'b0;
    step();
    instr = 32'hE591_2004;
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 6'd10, 32'h0000_003F};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({obs, in_ready} !== {exp_v, 1'b0}) begin
        errors++; $display("FAIL stall_hold cyc %0d got %h want %h", i, {obs, in_ready}, {exp_v, 1'b0});
      end
      step();
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL stall_release got %b want 01", {out_valid, in_ready});
    end
    step();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL stall_no_stray got %b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_rst_mid();
    regs[1] = 32'hAAAA_5555; regs[3] = 32'h0000_0150;
    instr = 32'hE1A0_0351; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (rf_rd_addr !== 4'd3) begin
      errors++; $display("FAIL rst_mid_rd_rs got %0d want 3", rf_rd_addr);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, in_ready, rf_rd_addr} !== 6'b01_0000) begin
      errors++; $display("FAIL rst_mid_idle got %b want 010000", {out_valid, in_ready, rf_rd_addr});
    end
    step();
    checks++;
    if (obs !== 45'd0) begin
      errors++; $display("FAIL rst_mid_no_output got %h want %h", obs, 45'd0);
    end
  endtask

  task automatic test_illegal(input logic [31:0] iw);
    instr = iw; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 6'd0, 32'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++; $display("FAIL illegal_op %h got %h want %h", iw, obs, exp_v);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + i;
    test_reset();
    test_dp_imm();
    test_imm_shift(32'hE1A0_0022, 32'h8000_0000, 3'd1, 6'd32);  // LSR #0
    test_imm_shift(32'hE1A0_0042, 32'h8000_0001, 3'd2, 6'd32);  // ASR #0
    test_imm_shift(32'hE1A0_0062, 32'h0000_00F0, 3'd3, 6'd0);   // ROR #0
    test_imm_shift(32'hE1A0_0285, 32'h0000_0003, 3'd0, 6'd5);   // LSL #5
    test_reg_shift(32'hE1A0_0351, 32'h1234_5678, 32'h0000_0150, 3'd2, 6'd32);
    test_reg_shift(32'hE1A0_0371, 32'h1234_5678, 32'h0000_0150, 3'd3, 6'd16);
    test_reg_shift(32'hE1A0_0311, 32'h0000_0001, 32'h0000_001F, 3'd0, 6'd31);
    test_reg_shift(32'hE1A0_0311, 32'h0000_0001, 32'h0000_0120, 3'd0, 6'd32);
    test_ls_imm();
    test_branch();
    test_stall();
    test_rst_mid();
    test_illegal(32'hEE00_0000);
    test_illegal(32'hE000_0091);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
